// File: rtl/sorted_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sorted_ram_writer
//  Description : Fills the search RAM with an ascending sequence, one word
//                per Valid strobe. Words that would break the ordering are
//                rejected and flagged on the sticky Error output. Reports
//                word count and completion once the RAM is full.
//  Options     : STRICT_ASCEND_EN - when defined, each accepted word must be
//                strictly greater than the previous one (duplicates rejected);
//                otherwise equal values are accepted (non-decreasing order).
//  Revision    : 1.0 - initial release
// ============================================================================
module sorted_ram_writer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Data,
    input  logic              Valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              Ready,
    output logic [ADDR_W:0]   Count,
    output logic              Done,
    output logic              Error
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Count value held just before the final word is accepted
    localparam logic [ADDR_W:0] c_LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_ready;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_error;
    logic [DATA_W-1:0] r_last;
    logic              r_have_last;

    logic              w_order_ok;
    logic              w_accept;

    // Ordering rule against the last accepted word (unsigned compare)
`ifdef STRICT_ASCEND_EN
    assign w_order_ok = (Data > r_last);
`else
    assign w_order_ok = (Data >= r_last);
`endif

    // The first word of a session has nothing to be ordered against
    assign w_accept = !r_have_last || w_order_ok;

    // Session FSM with all outputs registered; Start always takes priority over Valid
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_ready     <= 1'b0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_last      <= '0;
            r_have_last <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (Start) begin
                // Begin a fresh session from any state; a coincident Valid is dropped
                r_state     <= c_ST_LOAD;
                r_ready     <= 1'b1;
                r_done      <= 1'b0;
                r_count     <= '0;
                r_error     <= 1'b0;
                r_have_last <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_LOAD: begin
                        if (Valid) begin
                            if (w_accept) begin
                                r_wr_en     <= 1'b1;
                                r_wr_addr   <= r_count[ADDR_W-1:0];
                                r_wr_data   <= Data;
                                r_last      <= Data;
                                r_have_last <= 1'b1;
                                r_count     <= r_count + c_ONE;
                                if (r_count == c_LAST_IDX) begin
                                    r_state <= c_ST_DONE;
                                    r_ready <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    c_ST_DONE: begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign Ready   = r_ready;
    assign Count   = r_count;
    assign Done    = r_done;
    assign Error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sorted_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sorted_ram_writer
//  Description : Directed self-checking bench for sorted_ram_writer.
//                Honours STRICT_ASCEND_EN for the duplicate-value case.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sorted_ram_writer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic              clk;
    logic              Reset;
    logic              Start;
    logic [DATA_W-1:0] Data;
    logic              Valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              Ready;
    logic [ADDR_W:0]   Count;
    logic              Done;
    logic              Error;

    int n_cmp;
    int n_err;

    sorted_ram_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .Reset   (Reset),
        .Start   (Start),
        .Data    (Data),
        .Valid   (Valid),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .Ready   (Ready),
        .Count   (Count),
        .Done    (Done),
        .Error   (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int e_en, input int e_ready,
                              input int e_count, input int e_done, input int e_error);
        check({tag, ".wr_en"}, 32'(wr_en), e_en);
        check({tag, ".ready"}, 32'(Ready), e_ready);
        check({tag, ".count"}, 32'(Count), e_count);
        check({tag, ".done"},  32'(Done),  e_done);
        check({tag, ".error"}, 32'(Error), e_error);
    endtask

    task automatic write_word(input int value);
        Valid = 1'b1;
        Data  = 8'(value);
        tick();
        Valid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        Start = 1'b0;
        Valid = 1'b0;
        Data  = '0;
        tick();
        tick();

        // Reset values
        check_outs("reset", 0, 0, 0, 0, 0);
        check("reset.addr", 32'(wr_addr), 0);
        check("reset.data", 32'(wr_data), 0);
        Reset = 1'b0;
        tick();

        // Valid in IDLE is ignored
        write_word(5);
        check_outs("idle_valid", 0, 0, 0, 0, 0);

        // Start enters LOAD
        pulse_start();
        check_outs("start", 0, 1, 0, 0, 0);

        // Full load with back-to-back strobes 0,2,..,62
        for (int i = 0; i < 32; i++) begin
            Valid = 1'b1;
            Data  = 8'(2 * i);
            tick();
            check("fill.wr_en", 32'(wr_en),   1);
            check("fill.addr",  32'(wr_addr), i);
            check("fill.data",  32'(wr_data), 2 * i);
            check("fill.count", 32'(Count),   i + 1);
            if (i < 31) begin
                check("fill.ready", 32'(Ready), 1);
                check("fill.done",  32'(Done),  0);
            end
        end
        Valid = 1'b0;
        check_outs("full", 1, 0, 32, 1, 0);
        tick();
        check_outs("full_after", 0, 0, 32, 1, 0);

        // Valid in DONE is ignored
        write_word(100);
        check_outs("done_valid", 0, 0, 32, 1, 0);

        // Start in DONE opens a fresh session
        pulse_start();
        check_outs("done_start", 0, 1, 0, 0, 0);

        // Ordering violation: 10 then 5 rejected, 12 lands at addr 1
        write_word(10);
        check_outs("ord10", 1, 1, 1, 0, 0);
        check("ord10.addr", 32'(wr_addr), 0);
        write_word(5);
        check_outs("ord5", 0, 1, 1, 0, 1);
        write_word(12);
        check_outs("ord12", 1, 1, 2, 0, 1);
        check("ord12.addr", 32'(wr_addr), 1);
        check("ord12.data", 32'(wr_data), 12);

        // Duplicate value handling
        pulse_start();
        check_outs("dup_start", 0, 1, 0, 0, 0);
        write_word(7);
        check_outs("dup_first", 1, 1, 1, 0, 0);
        write_word(7);
`ifdef STRICT_ASCEND_EN
        check_outs("dup_second", 0, 1, 1, 0, 1);
`else
        check_outs("dup_second", 1, 1, 2, 0, 0);
        check("dup_second.addr", 32'(wr_addr), 1);
`endif

        // Start with coincident Valid: word dropped, session restarted, Error cleared
        pulse_start();
        write_word(3);
        write_word(4);
        write_word(5);
        write_word(2);
        check_outs("pre_restart", 0, 1, 3, 0, 1);
        Start = 1'b1;
        Valid = 1'b1;
        Data  = 8'd99;
        tick();
        Start = 1'b0;
        Valid = 1'b0;
        check_outs("restart", 0, 1, 0, 0, 0);
        write_word(1);
        check_outs("restart_w", 1, 1, 1, 0, 0);
        check("restart_w.addr", 32'(wr_addr), 0);
        check("restart_w.data", 32'(wr_data), 1);

        // Reset mid-LOAD at Count=10 together with a Valid
        pulse_start();
        for (int i = 0; i < 10; i++) write_word(i);
        check_outs("pre_reset", 1, 1, 10, 0, 0);
        Valid = 1'b1;
        Data  = 8'd50;
        Reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 0);
        tick();
        check_outs("reset_hold", 0, 0, 0, 0, 0);
        check("reset_hold.addr", 32'(wr_addr), 0);
        check("reset_hold.data", 32'(wr_data), 0);
        Reset = 1'b0;
        Data  = 8'd60;
        tick();
        Valid = 1'b0;
        check_outs("post_reset_valid", 0, 0, 0, 0, 0);
        pulse_start();
        check_outs("post_reset_start", 0, 1, 0, 0, 0);
        write_word(60);
        check_outs("post_reset_w", 1, 1, 1, 0, 0);
        check("post_reset_w.addr", 32'(wr_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sorted_ram_writer.md
# sorted_ram_writer

Loader that fills the 32-word search RAM with an ascending sequence of values, one value per input strobe. It enforces ordering so the binary-search reader always sees sorted data, and reports completion, word count and ordering violations. It sits between the operator inputs (switches/keys, already synchronized) and the RAM write port, as the writer counterpart of the search engine that reads the RAM.

## Interface
Parameters:
- ADDR_W, 5, RAM address width; capacity is 2^ADDR_W words.
- DATA_W, 8, word width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle pulse; begins (or restarts) a load session.
- Data  in  DATA_W  candidate value, sampled when Valid=1.
- Valid  in  1  single-cycle strobe presenting Data.
- wr_en  out  1  RAM write enable, one-cycle pulse per accepted word.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- Ready  out  1  high while in LOAD; Valid is honoured only then.
- Count  out  ADDR_W+1  number of words accepted this session (0..2^ADDR_W).
- Done  out  1  high in DONE state.
- Error  out  1  sticky; a word was rejected for ordering this session.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: Ready=0, Done=0. Start -> LOAD. Valid ignored.
- On entry to LOAD via Start: Count=0, next address=0, last-value register marked empty, Error cleared.
- LOAD with Valid=1:
  - If no word accepted yet, or Data passes the order check against the last accepted value: accept. Write Data at address Count, store Data as last value, Count+1.
  - Otherwise: reject. No write, Count unchanged, Error=1.
- Order check: Data >= last, unsigned DATA_W compare. See Configuration.
- When Count reaches 2^ADDR_W: LOAD -> DONE. Count holds 2^ADDR_W. The width of Count is ADDR_W+1 so this value does not wrap.
- DONE: Done=1, Ready=0. Valid ignored. Start -> LOAD, a fresh session.
- Start during LOAD aborts the session and restarts it as above. Words already written stay in RAM and will be overwritten.
- Start and Valid in the same cycle: Start wins. The word is dropped, no write, Error unaffected except for the clear.
- Reset in any state: immediately return to IDLE with all outputs at their reset values. A write pending in that cycle is discarded.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, Ready=0, Count=0, Done=0, Error=0. State IDLE.
- All outputs are registered.
- Start at edge N -> state LOAD and Ready=1 from N+1.
- Valid accepted at edge N -> wr_en=1 with wr_addr and wr_data valid for exactly cycle N+1. Count increments at N+1.
- Rejected Valid at edge N -> Error=1 from N+1. wr_en stays 0.
- Accepting the 2^ADDR_W-th word at edge N -> Done=1, Ready=0 and Count=2^ADDR_W, all from N+1, coincident with the final wr_en pulse.
- Back-to-back Valid on consecutive cycles is supported: one write per cycle and no stall.
- wr_en is never high for two cycles with the same address.

## Configuration
- Macro STRICT_ASCEND_EN:
  - Defined: the order check is Data > last (strictly increasing). Duplicates are rejected and set Error.
  - Undefined: the order check is Data >= last (non-decreasing). Duplicates are accepted.

## Test plan
- Reset then Start, then 32 Valid strobes with Data=0,2,4..62 -> 32 wr_en pulses at addr 0..31 with the matching data. Done=1 and Count=32 in the cycle after the 32nd strobe. Ready=0 afterwards.
- In LOAD, Data=10 accepted, then Data=5 -> no write, Error=1, Count=1. Next Data=12 -> written at addr 1.
- Data=7 then Data=7 -> second word written (Count=2) when STRICT_ASCEND_EN is undefined; rejected with Error=1 when it is defined.
- After 3 accepted words, Start pulsed together with Valid (Data=99) -> no write, Count=0, Error=0. Next Data=1 -> written at addr 0.
- Valid in IDLE and in DONE -> no wr_en, Count unchanged. Start in DONE -> LOAD, Count=0, Done=0.
- Reset asserted mid-LOAD at Count=10, in the same cycle as a Valid -> all outputs take their reset values with no wr_en pulse. After release, state IDLE and Start is required before further writes.
